// File: rtl/dcache_linefill.sv
// Data-cache line fill engine: issues one 8-beat burst read for a missing
// line and streams each returned beat into four 32x8 byte-lane RAMs at
// {line, word}. A memory error during the burst aborts the fill.
module dcache_linefill #(
  parameter int LINES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fill_req,
  input  logic [26:0]                fill_addr,
  input  logic [$clog2(LINES)-1:0]   fill_line,
  output logic                       fill_busy,
  output logic                       fill_done,
  output logic                       fill_err,
  output logic                       mem_rdreq,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_rdvalid,
  input  logic                       mem_err,
  output logic [$clog2(LINES)+2:0]   ram_waddr,
  output logic [31:0]                ram_datain,
  output logic [3:0]                 ram_we
);

  localparam int LINE_W = $clog2(LINES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    BURST = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [26:0]         addr_reg, addr_next;
  logic [LINE_W-1:0]   line_reg, line_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic [3:0]          we_reg, we_next;
  logic [LINE_W+2:0]   waddr_reg, waddr_next;
  logic [31:0]         wdata_reg, wdata_next;

  // State and datapath registers; everything visible at the ports comes from
  // here, so an asserted reset clears all outputs without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      line_reg  <= '0;
      cnt_reg   <= '0;
      we_reg    <= '0;
      waddr_reg <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      line_reg  <= line_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  // Next-state and datapath updates; RAM write strobe defaults to idle so it
  // only fires in the cycle after an accepted beat.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    line_next  = line_reg;
    cnt_next   = cnt_reg;
    we_next    = 4'b0000;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (fill_req) begin
          addr_next  = fill_addr;
          line_next  = fill_line;
          cnt_next   = 3'd0;
          state_next = REQ;
        end
      end
      REQ: begin
        // Beats or errors arriving before the ack are not ours; ignore them.
        if (mem_ack) begin
          state_next = BURST;
        end
      end
      BURST: begin
        if (mem_err) begin
          // Error wins over a coincident beat: that beat is never written.
          state_next = ERR;
        end else if (mem_rdvalid) begin
          we_next    = 4'b1111;
          waddr_next = {line_reg, cnt_reg};
          wdata_next = mem_rdata;
          cnt_next   = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fill_busy  = (state_reg != IDLE);
  assign fill_done  = (state_reg == DONE);
  assign fill_err   = (state_reg == ERR);
  assign mem_rdreq  = (state_reg == REQ);
  assign mem_addr   = {addr_reg, 5'b00000};
  assign ram_we     = we_reg;
  assign ram_waddr  = waddr_reg;
  assign ram_datain = wdata_reg;

endmodule

// File: tb/tb_dcache_linefill.sv
// Scoreboard bench for dcache_linefill: the stimulus side pushes every
// expected RAM write and error pulse; a negedge monitor pops and compares.
module tb_dcache_linefill;

  logic        clk;
  logic        reset_n;
  logic        fill_req;
  logic [26:0] fill_addr;
  logic [1:0]  fill_line;
  logic        fill_busy;
  logic        fill_done;
  logic        fill_err;
  logic        mem_rdreq;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_rdvalid;
  logic        mem_err;
  logic [4:0]  ram_waddr;
  logic [31:0] ram_datain;
  logic [3:0]  ram_we;

  dcache_linefill #(.LINES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .fill_line   (fill_line),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .fill_err    (fill_err),
    .mem_rdreq   (mem_rdreq),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_rdvalid (mem_rdvalid),
    .mem_err     (mem_err),
    .ram_waddr   (ram_waddr),
    .ram_datain  (ram_datain),
    .ram_we      (ram_we)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic        done;
  } wr_t;

  wr_t wq[$];
  int  err_pending = 0;
  int  checks = 0;
  int  fails = 0;
  int  gaps[8] = '{0, 2, 4, 1, 3, 0, 4, 2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (ram_we != 4'b0000) begin
      if (wq.size() == 0) begin
        check("unexpected_write_addr", {59'd0, ram_waddr}, 64'h7f);
      end else begin
        e = wq.pop_front();
        check("ram_we", {60'd0, ram_we}, 64'hf);
        check("ram_waddr", {59'd0, ram_waddr}, {59'd0, e.a});
        check("ram_datain", {32'd0, ram_datain}, {32'd0, e.d});
        check("fill_done_with_write", {63'd0, fill_done}, {63'd0, e.done});
      end
    end else if (fill_done) begin
      check("fill_done_without_write", {63'd0, fill_done}, 64'd0);
    end
    if (fill_err) begin
      check("fill_err_expected", {63'd0, (err_pending > 0)}, 64'd1);
      if (err_pending > 0) err_pending--;
    end
  end

  // One complete fill. err_beat/rst_beat < 0 disables that event.
  task automatic run_fill(input logic [26:0] a, input logic [1:0] ln, input int ack_dly,
                          input bit gap_mode, input int err_beat, input int rst_beat,
                          input bit noise, input bit req_in_burst, input bit req_in_done);
    logic [31:0] data;
    wr_t e;
    fill_addr = a;
    fill_line = ln;
    fill_req  = 1'b1;
    tick();
    fill_req  = 1'b0;
    fill_addr = ~a;
    fill_line = ~ln;
    check("busy_after_accept", {63'd0, fill_busy}, 64'd1);
    check("rdreq_in_req", {63'd0, mem_rdreq}, 64'd1);
    check("mem_addr", {32'd0, mem_addr}, {32'd0, a, 5'b00000});
    for (int i = 0; i < ack_dly; i++) begin
      if (noise) begin
        mem_rdvalid = 1'b1;
        mem_rdata   = 32'hdeadbeef;
        mem_err     = (i == 1);
      end
      tick();
      mem_rdvalid = 1'b0;
      mem_err     = 1'b0;
    end
    check("rdreq_held", {63'd0, mem_rdreq}, 64'd1);
    check("mem_addr_held", {32'd0, mem_addr}, {32'd0, a, 5'b00000});
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rdreq_drop", {63'd0, mem_rdreq}, 64'd0);
    for (int n = 0; n < 8; n++) begin
      if (gap_mode) begin
        for (int g = 0; g < gaps[n]; g++) tick();
      end
      if (req_in_burst && n == 3) begin
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        check("req_ignored_in_burst", {62'd0, mem_rdreq, fill_busy}, 64'd1);
      end
      data = 32'h03020100 + n * 32'h04040404;
      if (n == rst_beat) begin
        tick();
        mem_rdvalid = 1'b1;
        mem_rdata   = data;
        reset_n     = 1'b0;
        #1;
        check("async_reset_outputs", {63'd0, |{fill_busy, fill_done, fill_err, mem_rdreq,
              mem_addr, ram_we, ram_waddr, ram_datain}}, 64'd0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        mem_rdvalid = 1'b0;
        check("idle_after_reset", {62'd0, fill_busy, mem_rdreq}, 64'd0);
        return;
      end
      mem_rdvalid = 1'b1;
      mem_rdata   = data;
      if (n == err_beat) begin
        mem_err = 1'b1;
        err_pending++;
      end else begin
        e.a    = {ln, n[2:0]};
        e.d    = data;
        e.done = (n == 7);
        wq.push_back(e);
      end
      tick();
      mem_rdvalid = 1'b0;
      mem_err     = 1'b0;
      if (n == err_beat) begin
        check("busy_in_err", {63'd0, fill_busy}, 64'd1);
        tick();
        check("busy_low_after_err", {63'd0, fill_busy}, 64'd0);
        return;
      end
    end
    check("busy_in_done", {63'd0, fill_busy}, 64'd1);
    if (req_in_done) fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    check("idle_after_done", {62'd0, fill_busy, mem_rdreq}, 64'd0);
    tick();
    check("rdreq_stays_low", {63'd0, mem_rdreq}, 64'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    fill_req    = 1'b0;
    fill_addr   = '0;
    fill_line   = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    mem_rdvalid = 1'b0;
    mem_err     = 1'b0;
    tick();
    tick();
    check("reset_state", {63'd0, |{fill_busy, fill_done, fill_err, mem_rdreq,
          mem_addr, ram_we, ram_waddr, ram_datain}}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Back-to-back beats into line 2, ack after 3 cycles.
    run_fill(27'h0000123, 2'd2, 3, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0);
    // Gapped beats into line 0.
    run_fill(27'h0000abc, 2'd0, 1, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0);
    // Memory error on the 5th beat, line 1.
    run_fill(27'h1234567, 2'd1, 2, 1'b0, 4, -1, 1'b0, 1'b0, 1'b0);
    // Extra requests during BURST and in the DONE cycle.
    run_fill(27'h7ffffff, 2'd3, 2, 1'b0, -1, -1, 1'b0, 1'b1, 1'b1);
    // Reset on the 4th beat.
    run_fill(27'h0000055, 2'd3, 1, 1'b0, -1, 3, 1'b0, 1'b0, 1'b0);
    // Beats and an error strobe in REQ before the ack.
    run_fill(27'h0001000, 2'd1, 3, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0);

    tick();
    tick();
    check("scoreboard_drained", {32'd0, wq.size()}, 64'd0);
    check("err_pulses_seen", {32'd0, err_pending}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dcache_linefill.md
DCACHE_LINEFILL -- requirements
Module: dcache_linefill

Interface
REQ-001 Parameter: LINES, default 4, number of cache lines held in the 32-entry byte-lane RAMs; fixed at 4 for 8 words x 4 lines = 32 entries.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 fill_req  input  1  pulse/level, start a line fill; sampled only in IDLE.
REQ-005 fill_addr  input  27  line address bits [31:5] of the missing line.
REQ-006 fill_line  input  2  destination line slot in the RAMs.
REQ-007 fill_busy  output  1  high from accepted request until DONE/ERR cycle inclusive.
REQ-008 fill_done  output  1  one-cycle pulse, line completely written.
REQ-009 fill_err  output  1  one-cycle pulse, fill aborted by memory error.
REQ-010 mem_rdreq  output  1  burst read request to memory.
REQ-011 mem_addr  output  32  burst start address, {fill_addr,5'b0}.
REQ-012 mem_ack  input  1  memory accepted request.
REQ-013 mem_rdata  input  32  beat data, little-endian bytes.
REQ-014 mem_rdvalid  input  1  beat strobe.
REQ-015 mem_err  input  1  memory error strobe.
REQ-016 ram_waddr  output  5  write address to four 32x8 byte-lane RAMs, {line,word}.
REQ-017 ram_datain  output  32  byte lane n = bits [8n+7:8n].
REQ-018 ram_we  output  4  per-lane write enables.

Function
REQ-019 States SHALL be IDLE, REQ, BURST, DONE, ERR; encoded in a registered state variable.
REQ-020 IDLE: on fill_req=1, latch fill_addr and fill_line, clear beat counter, go REQ next cycle; fill_busy rises same edge.
REQ-021 REQ: mem_rdreq=1, mem_addr={latched addr,5'b0} held stable until mem_ack=1; on mem_ack go BURST, mem_rdreq drops next cycle.
REQ-022 mem_rdvalid or mem_err while in REQ before mem_ack SHALL be ignored.
REQ-023 BURST: each mem_rdvalid=1 cycle registers one beat: next cycle ram_we=4'b1111, ram_waddr={line,cnt[2:0]}, ram_datain=mem_rdata; cnt increments by 1.
REQ-024 Write latency SHALL be exactly 1 cycle from mem_rdvalid to ram_we; gaps between beats allowed, ram_we=0 in gap cycles.
REQ-025 On the 8th beat (cnt=7) go DONE; cnt wraps to 0; no further beats accepted.
REQ-026 DONE: fill_done=1 for one cycle (same cycle as the 8th RAM write), then IDLE.
REQ-027 mem_err=1 in BURST SHALL abort: go ERR, no RAM write for that cycle, fill_err=1 one cycle, then IDLE; already-written words remain, done never pulses.
REQ-028 mem_err and mem_rdvalid same cycle: error wins, beat discarded.
REQ-029 fill_req while fill_busy=1 SHALL be ignored, not queued.
REQ-030 fill_req in the DONE/ERR cycle is ignored; new request accepted from IDLE only.
REQ-031 ram_we SHALL be 0 in all states except the cycle after an accepted beat.

Reset
REQ-032 reset_n=0 SHALL immediately force: state IDLE, cnt=0, fill_busy=0, fill_done=0, fill_err=0, mem_rdreq=0, mem_addr=0, ram_we=0, ram_waddr=0, ram_datain=0.
REQ-033 Reset mid-burst abandons the fill with no done/err pulse; remaining beats after release are ignored in IDLE.

Verification
REQ-034 fill_req, addr=27'h0000123, line=2; ack after 3 cycles; 8 back-to-back beats 32'h03020100+n*04040404 -> mem_addr=32'h00002460, writes addr 16..23, fill_done coincident with addr 23.
REQ-035 Beats with random 0-4 cycle gaps, line=0 -> ram_waddr 0..7 in order, ram_we only on beat+1 cycles.
REQ-036 mem_err on 5th beat, line=1 -> addrs 8..11 written, fill_err one pulse, no fill_done, busy low next cycle.
REQ-037 Second fill_req during BURST and in DONE cycle -> ignored; mem_rdreq stays 0 until request issued from IDLE.
REQ-038 reset_n low on 4th beat -> all outputs 0 asynchronously; subsequent mem_rdvalid produces no ram_we.
REQ-039 mem_rdvalid asserted in REQ before ack -> no write, cnt stays 0.
